axi_err_slv: RTL and testbench
==============================

# axi_err_slv

AXI4 responder that terminates every transaction the SoC crossbar routes to unmapped address space. Any access outside the DRAM, GPIO, Ethernet, SPI, UART, PLIC, CLINT, ROM and Debug windows goes to this block. It completes each access protocol-correctly with a DECERR response, so a bad pointer in software traps instead of hanging the bus. It sits on the crossbar's default-slave port, on the slave-side ID width (master ID plus crossbar routing bits).

## Interface
Parameters:
- ID_WIDTH, 6, AXI ID width on the slave side (IdWidth 4 + 2 routing bits).
- ADDR_WIDTH, 64, AXI address width.
- DATA_WIDTH, 64, AXI data width.
- RESP_DATA, 64'hCA11_AB1E_BADC_AB1E, value driven on rdata for every read beat.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- aw_id_i, aw_addr_i, aw_len_i[7:0], aw_valid_i  in  ID_WIDTH/ADDR_WIDTH/8/1  write address channel.
- aw_ready_o  out  1  write address ready.
- w_data_i, w_strb_i, w_last_i, w_valid_i  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel. Data and strobes are ignored.
- w_ready_o  out  1  write data ready.
- b_id_o, b_resp_o[1:0], b_valid_o  out  ID_WIDTH/2/1  write response channel.
- b_ready_i  in  1  write response ready.
- ar_id_i, ar_addr_i, ar_len_i[7:0], ar_valid_i  in  ID_WIDTH/ADDR_WIDTH/8/1  read address channel.
- ar_ready_o  out  1  read address ready.
- r_id_o, r_data_o, r_resp_o[1:0], r_last_o, r_valid_o  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data channel.
- r_ready_i  in  1  read data ready.
- err_addr_o  out  ADDR_WIDTH  captured faulting address (only with the macro; see Configuration).
- err_valid_o  out  1  sticky capture flag (only with the macro).
- err_clr_i  in  1  clears the capture flag (only with the macro).

## Operation
- The write and read paths are independent FSMs. They may be active at the same time.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: aw_ready_o=1 and w_ready_o=0. An AW handshake latches aw_id_i and moves to W_DATA.
  - W_DATA: w_ready_o=1. Beats are consumed and discarded. A W handshake with w_last_i=1 moves to W_RESP.
  - Burst length is taken from w_last_i only; aw_len_i is not checked.
  - W_RESP: b_valid_o=1, b_id_o=latched ID, b_resp_o=2'b11 (DECERR). A B handshake returns to W_IDLE.
- Read FSM, states R_IDLE, R_BURST:
  - R_IDLE: ar_ready_o=1. An AR handshake latches ar_id_i, loads the 8-bit beat counter with ar_len_i, and moves to R_BURST.
  - R_BURST: r_valid_o=1, r_id_o=latched ID, r_data_o=RESP_DATA, r_resp_o=2'b11.
  - r_last_o=1 exactly when the counter is 0.
  - Each R handshake decrements the counter. A handshake with the counter at 0 returns to R_IDLE.
  - ar_len_i=255 produces exactly 256 beats; the counter never wraps below 0.
- One outstanding transaction per direction. aw_ready_o and ar_ready_o stay low outside their idle states.
- The valid outputs and the held ID/data values stay stable until their handshake completes.
- Reset value of every output: all ready and valid outputs 0, except aw_ready_o=1 and ar_ready_o=1 after reset release. All IDs and r_last_o are 0, b_resp_o/r_resp_o are 2'b11, r_data_o=RESP_DATA, err_addr_o=0, err_valid_o=0.
- Reset asserted mid-burst: both FSMs return to idle immediately, valids drop asynchronously, and the partial burst is abandoned.

## Timing
- AW handshake in cycle n: w_ready_o=1 from cycle n+1.
- W handshake with w_last_i in cycle m: b_valid_o=1 in cycle m+1.
- B handshake in cycle k: aw_ready_o=1 in cycle k+1. A back-to-back write therefore costs at least 3 cycles for a single-beat burst.
- AR handshake in cycle n: first r_valid_o in cycle n+1. With r_ready_i held high, one beat is delivered per cycle.
- Final R handshake in cycle k: ar_ready_o=1 in cycle k+1.
- W beats presented before the AW handshake are stalled, not dropped.

## Configuration
- AXI_ERR_SLV_ADDR_CAPTURE_EN defined:
  - On an AW or AR handshake while err_valid_o=0, the block latches the address into err_addr_o and sets err_valid_o the next cycle.
  - Simultaneous AW and AR handshakes: the AW address wins.
  - err_clr_i clears err_valid_o. If it coincides with a capture, the capture wins and err_valid_o stays 1 with the new address.
  - err_addr_o holds its value until the next capture.
- AXI_ERR_SLV_ADDR_CAPTURE_EN not defined: err_addr_o is tied to 0 and err_valid_o to 0, err_clr_i is ignored, and there are no capture registers.

## Test plan
- Single write: AW id=6'h2A addr=64'h5000_0000 len=0, one W beat with wlast -> one B with b_id_o=6'h2A and b_resp_o=2'b11, one cycle after the W handshake.
- Read burst: AR id=6'h11 len=3, r_ready_i held 1 -> 4 beats on consecutive cycles, each r_data_o=RESP_DATA and r_resp_o=2'b11, r_last_o only on beat 4, then ar_ready_o=1 on the next cycle.
- Max burst with backpressure: AR len=255 with r_ready_i toggling randomly -> exactly 256 beats, r_id_o/r_data_o stable while stalled, r_last_o on the final beat only.
- Concurrent traffic: AW len=7 and AR len=7 issued in the same cycle -> both complete independently with correct IDs; with the macro on, err_addr_o=AW address.
- Reset mid-burst: rst_ni low after 2 of 8 read beats -> r_valid_o=0 immediately and ar_ready_o=1 after release; a new AR len=0 returns a single beat with r_last_o=1.
- Capture (macro on): read at 64'h7000_0000, then a write at 64'h5000_0000 -> err_addr_o stays 64'h7000_0000; after err_clr_i pulses, the next read at 64'h5800_0000 updates err_addr_o.

Source files
------------

// File: rtl/axi_err_slv.sv
// AXI4 default slave: completes every write and read with DECERR so that stray accesses trap instead of hanging the bus.
// Optional faulting-address capture is enabled by defining AXI_ERR_SLV_ADDR_CAPTURE_EN.
module axi_err_slv #(
  parameter int                    ID_WIDTH   = 6,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESP_DATA  = 64'hCA11_AB1E_BADC_AB1E
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ID_WIDTH-1:0]     aw_id_i,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]              aw_len_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                    w_last_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  output logic [ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]              b_resp_o,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  input  logic [ID_WIDTH-1:0]     ar_id_i,
  input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  output logic [ID_WIDTH-1:0]     r_id_o,
  output logic [DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [ADDR_WIDTH-1:0]   err_addr_o,
  output logic                    err_valid_o,
  input  logic                    err_clr_i
);

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE = 2'b00, W_DATA = 2'b01, W_RESP = 2'b10} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} r_state_t;

  w_state_t              w_state_r, w_state_s;
  r_state_t              r_state_r, r_state_s;
  logic [ID_WIDTH-1:0]   b_id_r;
  logic [ID_WIDTH-1:0]   r_id_r;
  logic [7:0]            r_cnt_r;
  logic                  aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

  assign aw_hs_s = aw_valid_i && aw_ready_o;
  assign w_hs_s  = w_valid_i && w_ready_o;
  assign b_hs_s  = b_valid_o && b_ready_i;
  assign ar_hs_s = ar_valid_i && ar_ready_o;
  assign r_hs_s  = r_valid_o && r_ready_i;

  // Write FSM state and latched AW ID
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_r <= W_IDLE;
      b_id_r    <= {ID_WIDTH{1'b0}};
    end else begin
      w_state_r <= w_state_s;
      if (aw_hs_s) begin
        b_id_r <= aw_id_i;
      end
    end
  end

  // Write FSM next state; burst end comes from w_last only
  always_comb begin
    w_state_s = w_state_r;
    case (w_state_r)
      W_IDLE:  if (aw_hs_s) w_state_s = W_DATA; else w_state_s = W_IDLE;
      W_DATA:  if (w_hs_s && w_last_i) w_state_s = W_RESP; else w_state_s = W_DATA;
      W_RESP:  if (b_hs_s) w_state_s = W_IDLE; else w_state_s = W_RESP;
      default: w_state_s = W_IDLE;
    endcase
  end

  // Write channel outputs decoded from the state register
  always_comb begin
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    case (w_state_r)
      W_IDLE:  aw_ready_o = 1'b1;
      W_DATA:  w_ready_o  = 1'b1;
      W_RESP:  b_valid_o  = 1'b1;
      default: aw_ready_o = 1'b0;
    endcase
  end

  assign b_id_o   = b_id_r;
  assign b_resp_o = RESP_DECERR;

  // Read FSM state, latched AR ID and remaining-beat counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_r <= R_IDLE;
      r_id_r    <= {ID_WIDTH{1'b0}};
      r_cnt_r   <= 8'd0;
    end else begin
      r_state_r <= r_state_s;
      if (ar_hs_s) begin
        r_id_r  <= ar_id_i;
        r_cnt_r <= ar_len_i;
      end else if (r_hs_s && (r_cnt_r != 8'd0)) begin
        r_cnt_r <= r_cnt_r - 8'd1;
      end
    end
  end

  // Read FSM next state; the beat taken at count 0 is the last one
  always_comb begin
    r_state_s = r_state_r;
    case (r_state_r)
      R_IDLE:  if (ar_hs_s) r_state_s = R_BURST; else r_state_s = R_IDLE;
      R_BURST: if (r_hs_s && (r_cnt_r == 8'd0)) r_state_s = R_IDLE; else r_state_s = R_BURST;
      default: r_state_s = R_IDLE;
    endcase
  end

  // Read channel outputs decoded from the state register
  always_comb begin
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_last_o   = 1'b0;
    case (r_state_r)
      R_IDLE:  ar_ready_o = 1'b1;
      R_BURST: begin
        r_valid_o = 1'b1;
        r_last_o  = (r_cnt_r == 8'd0);
      end
      default: ar_ready_o = 1'b0;
    endcase
  end

  assign r_id_o   = r_id_r;
  assign r_data_o = RESP_DATA;
  assign r_resp_o = RESP_DECERR;

`ifdef AXI_ERR_SLV_ADDR_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] err_addr_r;
  logic                  err_valid_r;
  logic                  unused_s;

  // First faulting address after a clear is held; AW wins a tie with AR
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_addr_r  <= {ADDR_WIDTH{1'b0}};
      err_valid_r <= 1'b0;
    end else if (!err_valid_r && (aw_hs_s || ar_hs_s)) begin
      err_addr_r  <= aw_hs_s ? aw_addr_i : ar_addr_i;
      err_valid_r <= 1'b1;
    end else if (err_clr_i) begin
      err_valid_r <= 1'b0;
    end
  end

  assign err_addr_o  = err_addr_r;
  assign err_valid_o = err_valid_r;
  assign unused_s    = ^{w_data_i, w_strb_i, aw_len_i};
`else
  logic unused_s;

  assign err_addr_o  = {ADDR_WIDTH{1'b0}};
  assign err_valid_o = 1'b0;
  assign unused_s    = ^{w_data_i, w_strb_i, aw_len_i, aw_addr_i, ar_addr_i, err_clr_i};
`endif

endmodule

// File: tb/tb_axi_err_slv.sv
// Randomized self-checking bench for axi_err_slv; expectations come from a transaction-level model
// (beat counts, IDs, fixed DECERR/RESP_DATA, one-cycle handshake latencies).
module tb_axi_err_slv;
  localparam logic [63:0] RESP = 64'hCA11_AB1E_BADC_AB1E;

  logic        clk_i, rst_ni;
  logic [5:0]  aw_id_i, ar_id_i, b_id_o, r_id_o;
  logic [63:0] aw_addr_i, ar_addr_i, w_data_i, r_data_o, err_addr_o;
  logic [7:0]  aw_len_i, ar_len_i, w_strb_i;
  logic        aw_valid_i, aw_ready_o, w_last_i, w_valid_i, w_ready_o;
  logic [1:0]  b_resp_o, r_resp_o;
  logic        b_valid_o, b_ready_i, ar_valid_i, ar_ready_o;
  logic        r_last_o, r_valid_o, r_ready_i, err_valid_o, err_clr_i;

  int checks = 0;
  int errors = 0;

  axi_err_slv dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o), .r_valid_o(r_valid_o),
    .r_ready_i(r_ready_i),
    .err_addr_o(err_addr_o), .err_valid_o(err_valid_o), .err_clr_i(err_clr_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst_ni = 1'b0;
    aw_id_i = 6'd0; aw_addr_i = 64'd0; aw_len_i = 8'd0; aw_valid_i = 1'b0;
    w_data_i = 64'd0; w_strb_i = 8'd0; w_last_i = 1'b0; w_valid_i = 1'b0; b_ready_i = 1'b0;
    ar_id_i = 6'd0; ar_addr_i = 64'd0; ar_len_i = 8'd0; ar_valid_i = 1'b0; r_ready_i = 1'b0;
    err_clr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o, r_last_o} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctrl got aw_rdy,ar_rdy,w_rdy,b_vld,r_vld,r_last=%b exp 110000",
               {aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o, r_last_o});
    end
    checks++;
    if ({b_id_o, r_id_o, b_resp_o, r_resp_o} !== {12'd0, 4'b1111} || r_data_o !== RESP) begin
      errors++;
      $display("FAIL reset_data got b_id=%h r_id=%h b_resp=%b r_resp=%b r_data=%h exp 0 0 11 11 %h",
               b_id_o, r_id_o, b_resp_o, r_resp_o, r_data_o, RESP);
    end
    checks++;
    if (err_valid_o !== 1'b0 || err_addr_o !== 64'd0) begin
      errors++;
      $display("FAIL reset_err got valid=%b addr=%h exp 0 0", err_valid_o, err_addr_o);
    end
  endtask

  // Issues one AR and consumes the burst; starts and ends on a falling edge.
  task automatic run_read(input logic [5:0] id, input logic [7:0] len, input logic [63:0] addr,
                          input bit rnd, input bit clr_at_ar);
    int beats, cyc;
    bit rv;
    checks++;
    if (ar_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rd_idle got ar_ready=%b exp 1", ar_ready_o);
    end
    ar_valid_i = 1'b1; ar_id_i = id; ar_len_i = len; ar_addr_i = addr; err_clr_i = clr_at_ar;
    @(negedge clk_i);
    ar_valid_i = 1'b0; err_clr_i = 1'b0;
    beats = 0; cyc = 0;
    while (beats <= int'(len) && cyc < 3000) begin
      rv = r_valid_o;
      checks++;
      if ({r_valid_o, ar_ready_o} !== 2'b10) begin
        errors++;
        $display("FAIL rd_valid beat %0d got r_valid,ar_ready=%b exp 10", beats, {r_valid_o, ar_ready_o});
        break;
      end
      checks++;
      if (r_id_o !== id || r_data_o !== RESP || r_resp_o !== 2'b11) begin
        errors++;
        $display("FAIL rd_beat got id=%h data=%h resp=%b exp id=%h data=%h resp=11", r_id_o, r_data_o, r_resp_o, id, RESP);
      end
      checks++;
      if (r_last_o !== (beats == int'(len))) begin
        errors++;
        $display("FAIL rd_last beat %0d of %0d got %b exp %b", beats, int'(len) + 1, r_last_o, beats == int'(len));
      end
      r_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk_i);
      if (r_ready_i && rv) beats++;
      cyc++;
    end
    r_ready_i = 1'b0;
    checks++;
    if (beats != int'(len) + 1) begin
      errors++;
      $display("FAIL rd_count got %0d beats exp %0d", beats, int'(len) + 1);
    end
    checks++;
    if ({r_valid_o, ar_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL rd_done got r_valid,ar_ready=%b exp 01", {r_valid_o, ar_ready_o});
    end
  endtask

  // Issues AW together with the first W beat (which must stall), sends nb beats, takes the B.
  task automatic run_write(input logic [5:0] id, input int nb, input logic [63:0] addr, input bit rnd);
    int wb, cyc, stall;
    checks++;
    if ({aw_ready_o, w_ready_o} !== 2'b10) begin
      errors++;
      $display("FAIL wr_idle got aw_ready,w_ready=%b exp 10", {aw_ready_o, w_ready_o});
    end
    aw_valid_i = 1'b1; aw_id_i = id; aw_addr_i = addr; aw_len_i = 8'($urandom);
    w_valid_i = 1'b1; w_last_i = (nb == 1); w_data_i = {$urandom, $urandom};
    @(negedge clk_i);
    aw_valid_i = 1'b0;
    checks++;
    if ({aw_ready_o, w_ready_o, b_valid_o} !== 3'b010) begin
      errors++;
      $display("FAIL wr_after_aw got aw_ready,w_ready,b_valid=%b exp 010", {aw_ready_o, w_ready_o, b_valid_o});
    end
    wb = 0; cyc = 0;
    while (wb < nb && cyc < 500) begin
      checks++;
      if ({w_ready_o, b_valid_o} !== 2'b10) begin
        errors++;
        $display("FAIL wr_data beat %0d got w_ready,b_valid=%b exp 10", wb, {w_ready_o, b_valid_o});
        break;
      end
      w_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      w_last_i = (wb == nb - 1);
      w_data_i = {$urandom, $urandom}; w_strb_i = 8'($urandom);
      @(negedge clk_i);
      if (w_valid_i) wb++;
      cyc++;
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
    checks++;
    if (wb != nb) begin
      errors++;
      $display("FAIL wr_count got %0d beats exp %0d", wb, nb);
    end
    checks++;
    if ({b_valid_o, w_ready_o, aw_ready_o} !== 3'b100 || b_id_o !== id || b_resp_o !== 2'b11) begin
      errors++;
      $display("FAIL wr_b got b_valid,w_ready,aw_ready=%b id=%h resp=%b exp 100 id=%h resp=11",
               {b_valid_o, w_ready_o, aw_ready_o}, b_id_o, b_resp_o, id);
    end
    stall = rnd ? $urandom_range(0, 2) : 0;
    repeat (stall) begin
      @(negedge clk_i);
      checks++;
      if (b_valid_o !== 1'b1 || b_id_o !== id) begin
        errors++;
        $display("FAIL wr_b_hold got b_valid=%b id=%h exp 1 id=%h", b_valid_o, b_id_o, id);
      end
    end
    b_ready_i = 1'b1;
    @(negedge clk_i);
    b_ready_i = 1'b0;
    checks++;
    if ({b_valid_o, aw_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL wr_done got b_valid,aw_ready=%b exp 01", {b_valid_o, aw_ready_o});
    end
  endtask

  task automatic pulse_clr;
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
  endtask

  task automatic test_single_write;
    run_write(6'h2A, 1, 64'h5000_0000, 1'b0);
  endtask

  task automatic test_read_burst;
    run_read(6'h11, 8'd3, 64'h6000_0000, 1'b0, 1'b0);
    repeat (4) run_read(6'($urandom), 8'($urandom_range(0, 15)), {$urandom, $urandom}, 1'b1, 1'b0);
  endtask

  task automatic test_max_burst;
    run_read(6'($urandom), 8'd255, 64'h6100_0000, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    repeat (6) run_write(6'($urandom), $urandom_range(1, 5), {$urandom, $urandom}, 1'b1);
  endtask

  task automatic test_concurrent;
    logic [5:0]  wid, rid;
    logic [63:0] waddr;
    int wb, rb, bc, cyc;
    bit rv, bv, wr;
    pulse_clr();
    wid = 6'($urandom); rid = wid ^ 6'h3F;
    waddr = {32'h0000_0005, $urandom};
    aw_valid_i = 1'b1; aw_id_i = wid; aw_addr_i = waddr; aw_len_i = 8'd7;
    ar_valid_i = 1'b1; ar_id_i = rid; ar_addr_i = 64'h7700_0000; ar_len_i = 8'd7;
    @(negedge clk_i);
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;
    r_ready_i = 1'b1; b_ready_i = 1'b1;
    wb = 0; rb = 0; bc = 0; cyc = 0;
    while ((rb < 8 || bc < 1) && cyc < 200) begin
      rv = r_valid_o; bv = b_valid_o; wr = w_ready_o;
      if (rv) begin
        checks++;
        if (r_id_o !== rid || r_last_o !== (rb == 7)) begin
          errors++;
          $display("FAIL conc_r beat %0d got id=%h last=%b exp id=%h last=%b", rb, r_id_o, r_last_o, rid, rb == 7);
        end
        rb++;
      end
      if (bv) begin
        checks++;
        if (b_id_o !== wid || wb != 8) begin
          errors++;
          $display("FAIL conc_b got id=%h after %0d beats exp id=%h after 8", b_id_o, wb, wid);
        end
        bc++;
      end
      w_valid_i = (wb < 8) && 1'($urandom_range(0, 1));
      w_last_i = (wb == 7);
      if (wr && w_valid_i) wb++;
      @(negedge clk_i);
      cyc++;
    end
    r_ready_i = 1'b0; b_ready_i = 1'b0; w_valid_i = 1'b0; w_last_i = 1'b0;
    checks++;
    if (rb != 8 || bc != 1 || {aw_ready_o, ar_ready_o} !== 2'b11) begin
      errors++;
      $display("FAIL conc_done got r_beats=%0d b=%0d aw_ready,ar_ready=%b exp 8 1 11", rb, bc, {aw_ready_o, ar_ready_o});
    end
`ifdef AXI_ERR_SLV_ADDR_CAPTURE_EN
    checks++;
    if (err_valid_o !== 1'b1 || err_addr_o !== waddr) begin
      errors++;
      $display("FAIL conc_capture got valid=%b addr=%h exp 1 %h", err_valid_o, err_addr_o, waddr);
    end
`endif
  endtask

  task automatic test_reset_mid_burst;
    ar_valid_i = 1'b1; ar_id_i = 6'h15; ar_len_i = 8'd7; ar_addr_i = 64'h6200_0000;
    @(negedge clk_i);
    ar_valid_i = 1'b0; r_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if (r_valid_o !== 1'b1 || r_last_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre got r_valid=%b r_last=%b exp 1 0", r_valid_o, r_last_o);
    end
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({r_valid_o, b_valid_o, err_valid_o} !== 3'b000) begin
      errors++;
      $display("FAIL rst_async got r_valid,b_valid,err_valid=%b exp 000", {r_valid_o, b_valid_o, err_valid_o});
    end
    @(negedge clk_i);
    rst_ni = 1'b1; r_ready_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({ar_ready_o, aw_ready_o, r_valid_o} !== 3'b110) begin
      errors++;
      $display("FAIL rst_release got ar_ready,aw_ready,r_valid=%b exp 110", {ar_ready_o, aw_ready_o, r_valid_o});
    end
    run_read(6'($urandom), 8'd0, 64'h6300_0000, 1'b0, 1'b0);
  endtask

  task automatic test_capture;
`ifdef AXI_ERR_SLV_ADDR_CAPTURE_EN
    pulse_clr();
    run_read(6'h01, 8'd0, 64'h7000_0000, 1'b0, 1'b0);
    checks++;
    if (err_valid_o !== 1'b1 || err_addr_o !== 64'h7000_0000) begin
      errors++;
      $display("FAIL cap_first got valid=%b addr=%h exp 1 70000000", err_valid_o, err_addr_o);
    end
    run_write(6'h02, 1, 64'h5000_0000, 1'b0);
    checks++;
    if (err_valid_o !== 1'b1 || err_addr_o !== 64'h7000_0000) begin
      errors++;
      $display("FAIL cap_sticky got valid=%b addr=%h exp 1 70000000", err_valid_o, err_addr_o);
    end
    pulse_clr();
    checks++;
    if (err_valid_o !== 1'b0 || err_addr_o !== 64'h7000_0000) begin
      errors++;
      $display("FAIL cap_clear got valid=%b addr=%h exp 0 70000000", err_valid_o, err_addr_o);
    end
    run_read(6'h03, 8'd1, 64'h5800_0000, 1'b0, 1'b1);
    checks++;
    if (err_valid_o !== 1'b1 || err_addr_o !== 64'h5800_0000) begin
      errors++;
      $display("FAIL cap_second got valid=%b addr=%h exp 1 58000000", err_valid_o, err_addr_o);
    end
`else
    run_read(6'h01, 8'd0, 64'h7000_0000, 1'b0, 1'b0);
    run_write(6'h02, 1, 64'h5000_0000, 1'b0);
    checks++;
    if (err_valid_o !== 1'b0 || err_addr_o !== 64'd0) begin
      errors++;
      $display("FAIL cap_off got valid=%b addr=%h exp 0 0", err_valid_o, err_addr_o);
    end
    pulse_clr();
    checks++;
    if (err_valid_o !== 1'b0 || err_addr_o !== 64'd0) begin
      errors++;
      $display("FAIL cap_off_clr got valid=%b addr=%h exp 0 0", err_valid_o, err_addr_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_max_burst();
    test_back_to_back();
    test_concurrent();
    test_reset_mid_burst();
    test_capture();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
